// File: rtl/multdiv_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_ctrl_if
//  Description : Control/status bundle between the mult/div sequencer and the
//                A/Q register datapath plus its requester.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multdiv_ctrl_if;
    logic       ctrl_MULT;
    logic       ctrl_DIV;
    logic [1:0] booth_bits;
    logic       a_sign;
    logic       divisor_zero;
    logic       ovf_check;

    logic       aq_in_enable;
    logic       aq_out_enable;
    logic       aq_load;
    logic       alu_en;
    logic       alu_sub;
    logic [1:0] shift_mode;
    logic       busy;
    logic       data_resultRDY;
    logic       data_exception;

    modport master (
        output ctrl_MULT, ctrl_DIV, booth_bits, a_sign, divisor_zero, ovf_check,
        input  aq_in_enable, aq_out_enable, aq_load, alu_en, alu_sub,
               shift_mode, busy, data_resultRDY, data_exception
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, booth_bits, a_sign, divisor_zero, ovf_check,
        output aq_in_enable, aq_out_enable, aq_load, alu_en, alu_sub,
               shift_mode, busy, data_resultRDY, data_exception
    );
endinterface
`default_nettype wire

// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_ctrl
//  Description : Booth multiply / non-restoring divide sequencer for the A/Q
//                register. Define MULTDIV_OVF_EN to report multiply overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  wire logic     clock,
    input  wire logic     reset,
    multdiv_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MSTEP = 3'd2;
    localparam logic [2:0] S_DSTEP = 3'd3;
    localparam logic [2:0] S_FIXUP = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(WIDTH - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op_div;
    logic             r_dz;
    logic             r_result_valid;
    logic             r_exc;

    logic             w_start;
    logic             w_last;
    logic             w_done_exc;

    logic             w_in_en;
    logic             w_out_en;
    logic             w_load;
    logic             w_alu_en;
    logic             w_alu_sub;
    logic [1:0]       w_shift;
    logic             w_busy;
    logic             w_rdy;
    logic             w_exc;

    assign w_start = bus.ctrl_MULT | bus.ctrl_DIV;
    assign w_last  = (r_cnt == C_LAST_STEP);

`ifdef MULTDIV_OVF_EN
    assign w_done_exc = r_dz | (~r_op_div & bus.ovf_check);
`else
    logic w_unused_ovf;
    assign w_unused_ovf = bus.ovf_check;
    assign w_done_exc   = r_dz;
`endif

    // A new start overrides whatever is in flight; MULT wins a tie.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_op_div       <= 1'b0;
            r_dz           <= 1'b0;
            r_result_valid <= 1'b0;
            r_exc          <= 1'b0;
        end else if (w_start) begin
            r_state        <= S_LOAD;
            r_cnt          <= '0;
            r_op_div       <= ~bus.ctrl_MULT;
            r_dz           <= 1'b0;
            r_result_valid <= 1'b0;
            r_exc          <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (r_op_div && bus.divisor_zero) begin
                        r_dz    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= r_op_div ? S_DSTEP : S_MSTEP;
                    end
                end
                S_MSTEP, S_DSTEP: begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= (r_state == S_MSTEP) ? S_DONE : S_FIXUP;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_FIXUP: begin
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state        <= S_IDLE;
                    r_result_valid <= 1'b1;
                    r_exc          <= w_done_exc;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are forced low for as long as reset is held.
    always_comb begin
        w_in_en   = 1'b0;
        w_load    = 1'b0;
        w_alu_en  = 1'b0;
        w_alu_sub = 1'b0;
        w_shift   = 2'b00;
        w_busy    = 1'b0;
        w_rdy     = 1'b0;
        w_exc     = 1'b0;
        w_out_en  = 1'b0;
        if (reset) begin
            case (r_state)
                S_LOAD: begin
                    w_load  = 1'b1;
                    w_in_en = 1'b1;
                    w_busy  = 1'b1;
                end
                S_MSTEP: begin
                    w_in_en   = 1'b1;
                    w_busy    = 1'b1;
                    w_shift   = 2'b01;
                    w_alu_en  = bus.booth_bits[1] ^ bus.booth_bits[0];
                    w_alu_sub = (bus.booth_bits == 2'b10);
                end
                S_DSTEP: begin
                    w_in_en   = 1'b1;
                    w_busy    = 1'b1;
                    w_shift   = 2'b10;
                    w_alu_en  = 1'b1;
                    w_alu_sub = ~bus.a_sign;
                end
                S_FIXUP: begin
                    w_busy   = 1'b1;
                    w_alu_en = bus.a_sign;
                    w_in_en  = bus.a_sign;
                end
                S_DONE: begin
                    w_rdy = 1'b1;
                    w_exc = w_done_exc;
                end
                default: begin
                    w_exc = r_exc & r_result_valid;
                end
            endcase
            w_out_en = r_result_valid & ~w_busy;
        end
    end

    assign bus.aq_in_enable   = w_in_en;
    assign bus.aq_out_enable  = w_out_en;
    assign bus.aq_load        = w_load;
    assign bus.alu_en         = w_alu_en;
    assign bus.alu_sub        = w_alu_sub;
    assign bus.shift_mode     = w_shift;
    assign bus.busy           = w_busy;
    assign bus.data_resultRDY = w_rdy;
    assign bus.data_exception = w_exc;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multdiv_ctrl
//  Description : Cycle-offset reference model plus A/Q datapath model for
//                multdiv_ctrl, with directed and random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_ctrl;

    localparam int W      = 32;
    localparam int DONE_M = W + 2;
    localparam int DONE_D = W + 3;
    localparam int DONE_Z = 2;
`ifdef MULTDIV_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    multdiv_ctrl_if bus_if ();

    multdiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clock (clk),
        .reset (rstn),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // offset since last start (0 = no operation in flight)
    int m_k        = 0;
    bit m_div      = 0;
    bit m_dz       = 0;
    bit m_valid    = 0;
    bit m_exc      = 0;
    bit m_done_exc = 0;

    int          dp_mode = 0;
    logic [31:0] dp_a, dp_q, dp_m, dp_q0;
    logic        dp_q1;

    // {in, oe, load, alu_en, alu_sub, shift[1:0], busy, rdy, exc}
    logic [9:0] cap;
    int         ds_cnt = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic dp_update();
        logic [64:0] t;
        if (!cap[9]) return;
        if (cap[7]) begin
            dp_a = '0; dp_q = dp_q0; dp_q1 = 1'b0;
        end else if (cap[4:3] == 2'b01) begin
            if (cap[6]) dp_a = cap[5] ? dp_a - dp_m : dp_a + dp_m;
            t = {dp_a, dp_q, dp_q1};
            t = {t[64], t[64:1]};
            {dp_a, dp_q, dp_q1} = t;
        end else if (cap[4:3] == 2'b10) begin
            {dp_a, dp_q} = {dp_a[30:0], dp_q, 1'b0};
            if (cap[6]) dp_a = cap[5] ? dp_a - dp_m : dp_a + dp_m;
            dp_q[0] = ~dp_a[31];
        end else if (cap[6]) begin
            dp_a = cap[5] ? dp_a - dp_m : dp_a + dp_m;
        end
    endtask

    task automatic step_cycle();
        logic [9:0] e;
        int dk;
        if (dp_mode != 0) begin
            bus_if.booth_bits = {dp_q[0], dp_q1};
            bus_if.a_sign     = dp_a[31];
        end else begin
            bus_if.booth_bits = 2'($urandom_range(3, 0));
            bus_if.a_sign     = 1'($urandom_range(1, 0));
        end
        @(negedge clk);
        dk = m_div ? (m_dz ? DONE_Z : DONE_D) : DONE_M;
        e = '0;
        m_done_exc = 1'b0;
        if (rstn) begin
            if (m_k == 1) begin
                e[9] = 1; e[7] = 1; e[2] = 1;
            end else if (m_k >= 2 && m_k <= W + 1 && !m_dz) begin
                e[9] = 1; e[2] = 1;
                if (!m_div) begin
                    e[4:3] = 2'b01;
                    e[6]   = (bus_if.booth_bits == 2'b01) || (bus_if.booth_bits == 2'b10);
                    e[5]   = (bus_if.booth_bits == 2'b10);
                end else begin
                    e[4:3] = 2'b10;
                    e[6]   = 1;
                    e[5]   = !bus_if.a_sign;
                end
            end else if (m_div && !m_dz && m_k == W + 2) begin
                e[2] = 1;
                e[6] = bus_if.a_sign;
                e[9] = bus_if.a_sign;
            end
            if (m_k != 0 && m_k == dk) begin
                m_done_exc = m_dz || (OVF && !m_div && bus_if.ovf_check);
                e[1] = 1;
                e[0] = m_done_exc;
            end else if (m_k == 0) begin
                e[0] = m_valid && m_exc;
            end
            e[8] = m_valid && !e[2];
        end
        cap = {bus_if.aq_in_enable, bus_if.aq_out_enable, bus_if.aq_load,
               bus_if.alu_en, bus_if.alu_sub, bus_if.shift_mode,
               bus_if.busy, bus_if.data_resultRDY, bus_if.data_exception};
        chk("outputs", longint'(cap), longint'(e));
        if (cap[9] && cap[4:3] == 2'b10) ds_cnt++;
        @(posedge clk);
        cyc++;
        if (!rstn) begin
            m_k = 0; m_valid = 0; m_exc = 0;
        end else if (bus_if.ctrl_MULT || bus_if.ctrl_DIV) begin
            m_k = 1; m_div = !bus_if.ctrl_MULT; m_dz = 0; m_valid = 0; m_exc = 0;
        end else if (m_k != 0) begin
            if (m_k == dk) begin
                m_k = 0; m_valid = 1; m_exc = m_done_exc;
            end else begin
                if (m_k == 1 && m_div && bus_if.divisor_zero) m_dz = 1;
                m_k++;
            end
        end
        if (rstn && dp_mode != 0) dp_update();
        #1;
    endtask

    task automatic run_op(input bit mul, input bit dv, input int abort_at,
                          output int lat, output int nrdy, output bit exc);
        int k;
        bus_if.ctrl_MULT = mul;
        bus_if.ctrl_DIV  = dv;
        step_cycle();
        bus_if.ctrl_MULT = 0;
        bus_if.ctrl_DIV  = 0;
        k = 0; lat = -1; nrdy = 0; exc = 0; ds_cnt = 0;
        for (int i = 1; i <= 80; i++) begin
            k++;
            if (i == abort_at) bus_if.ctrl_DIV = 1;
            step_cycle();
            if (cap[1]) begin
                nrdy++; lat = k; exc = cap[0];
            end
            if (i == abort_at) begin
                bus_if.ctrl_DIV = 0; k = 0; ds_cnt = 0;
            end
            if (lat >= 0) break;
        end
        chk("rdy_seen", longint'(lat >= 0), 1);
        repeat (2) begin
            step_cycle();
            if (cap[1]) nrdy++;
        end
    endtask

    int lat, nrdy;
    bit exc;

    initial begin
        bus_if.ctrl_MULT = 0; bus_if.ctrl_DIV = 0; bus_if.booth_bits = 0;
        bus_if.a_sign = 0; bus_if.divisor_zero = 0; bus_if.ovf_check = 0;
        rstn = 0;
        repeat (2) begin
            bus_if.ctrl_MULT    = 1'($urandom_range(1, 0));
            bus_if.ctrl_DIV     = 1'($urandom_range(1, 0));
            bus_if.divisor_zero = 1'($urandom_range(1, 0));
            bus_if.ovf_check    = 1'($urandom_range(1, 0));
            step_cycle();
            chk("reset_outs", longint'(cap), 0);
        end
        bus_if.ctrl_MULT = 0; bus_if.ctrl_DIV = 0;
        bus_if.divisor_zero = 0; bus_if.ovf_check = 0;
        rstn = 1;
        repeat (2) step_cycle();
        chk("idle_outs", longint'(cap), 0);

        // 7 * -3
        dp_mode = 1; dp_m = 32'd7; dp_q0 = 32'hFFFF_FFFD;
        run_op(1, 0, 0, lat, nrdy, exc);
        chk("mult_lat", lat, 34);
        chk("mult_prod", longint'({dp_a, dp_q}), longint'(64'hFFFF_FFFF_FFFF_FFEB));
        chk("mult_exc", exc, 0);
        chk("mult_oe", longint'(cap[8]), 1);

        // 100 / 7
        dp_mode = 2; dp_m = 32'd7; dp_q0 = 32'd100;
        run_op(0, 1, 0, lat, nrdy, exc);
        chk("div_lat", lat, 35);
        chk("div_dsteps", ds_cnt, 32);
        chk("div_quot", longint'(dp_q), 14);
        chk("div_rem", longint'(dp_a), 2);
        chk("div_exc", exc, 0);

        // divide by zero
        dp_mode = 0; bus_if.divisor_zero = 1;
        run_op(0, 1, 0, lat, nrdy, exc);
        chk("dz_lat", lat, 2);
        chk("dz_exc", exc, 1);
        chk("dz_dsteps", ds_cnt, 0);
        chk("dz_exc_held", longint'(cap[0]), 1);
        bus_if.divisor_zero = 0;

        // DIV restarts a MULT at step 10
        dp_mode = 2; dp_m = 32'd7; dp_q0 = 32'd100;
        run_op(1, 0, 11, lat, nrdy, exc);
        chk("abort_lat", lat, 35);
        chk("abort_nrdy", nrdy, 1);
        chk("abort_quot", longint'(dp_q), 14);

        // overflow flag on multiply
        dp_mode = 0; bus_if.ovf_check = 1;
        run_op(1, 0, 0, lat, nrdy, exc);
        chk("ovf_lat", lat, 34);
        chk("ovf_exc", exc, longint'(OVF));
        bus_if.ovf_check = 0;

        for (int i = 0; i < 3000; i++) begin
            rstn                = ($urandom_range(199, 0) != 0);
            bus_if.ctrl_MULT    = ($urandom_range(39, 0) == 0);
            bus_if.ctrl_DIV     = ($urandom_range(39, 0) == 0);
            bus_if.divisor_zero = ($urandom_range(3, 0) == 0);
            bus_if.ovf_check    = 1'($urandom_range(1, 0));
            step_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
